seven_seg_scan_ctrl: RTL

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// A written value is parked in a shadow register and only becomes the
// displayed (active) value at a frame boundary, so a scan never mixes two
// values. Each digit is lit for DIV cycles, separated by BLANK_CYC dark cycles.
// Optional feature macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (blank leading zeros).
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    OutPortIn,
    input  logic [4*NUM_DIGITS-1:0] data,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int DIG_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [DIG_W-1:0]        dig, dig_nxt;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
    logic [4*NUM_DIGITS-1:0] active, active_nxt;
    logic                    pending_nxt;
    logic                    frame_done_nxt;
    logic                    commit;
    logic [7:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    // Hex nibble to active-low segment pattern (dp off, bits6..0 = g..a).
    function automatic logic [7:0] encode(input logic [3:0] nib);
        case (nib)
            4'h0: encode = 8'hC0;
            4'h1: encode = 8'hF9;
            4'h2: encode = 8'hA4;
            4'h3: encode = 8'hB0;
            4'h4: encode = 8'h99;
            4'h5: encode = 8'h92;
            4'h6: encode = 8'h82;
            4'h7: encode = 8'hF8;
            4'h8: encode = 8'h80;
            4'h9: encode = 8'h90;
            4'hA: encode = 8'h88;
            4'hB: encode = 8'h83;
            4'hC: encode = 8'hC6;
            4'hD: encode = 8'hA1;
            4'hE: encode = 8'h86;
            4'hF: encode = 8'h8E;
        endcase
    endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_from;

    // zero_from[k] is set when every active nibble from k upward is zero.
    always_comb begin
        logic acc;
        acc       = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc          = acc && (active[4*i +: 4] == 4'h0);
            zero_from[i] = acc;
        end
    end
`endif

    // Next-state, commit/write handling and next registered outputs.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        dig_nxt        = dig;
        shadow_nxt     = shadow;
        active_nxt     = active;
        pending_nxt    = pending;
        frame_done_nxt = 1'b0;
        commit         = 1'b0;
        an_nxt         = '1;
        seg_nxt        = 8'hFF;

        case (state)
            IDLE: begin
                if (pending) begin
                    commit    = 1'b1;
                    dig_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = BLANK;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SHOW;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SHOW: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = BLANK;
                    if (dig == DIG_LAST) begin
                        dig_nxt        = '0;
                        frame_done_nxt = 1'b1;
                        commit         = pending;
                    end else begin
                        dig_nxt = dig + DIG_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Commit takes the old shadow; a same-cycle write refills it and
        // keeps pending set for the following frame.
        if (commit) begin
            active_nxt  = shadow;
            pending_nxt = 1'b0;
        end
        if (OutPortIn) begin
            shadow_nxt  = data;
            pending_nxt = 1'b1;
        end

        // Active only changes on entry to BLANK, so it is stable for SHOW.
        if (state_nxt == SHOW) begin
            an_nxt[dig_nxt] = 1'b0;
            seg_nxt         = encode(active[{dig_nxt, 2'b00} +: 4]);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if ((dig_nxt != '0) && zero_from[dig_nxt]) begin
                seg_nxt = 8'hFF;
            end
`endif
        end
    end

    // State, data and registered output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dig        <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= '1;
            seg        <= 8'hFF;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dig        <= dig_nxt;
            shadow     <= shadow_nxt;
            active     <= active_nxt;
            pending    <= pending_nxt;
            frame_done <= frame_done_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
        end
    end

endmodule
